i2c_sequencer: RTL and testbench

I2C_SEQUENCER -- requirements
Module: i2c_sequencer

---
 rtl/i2c_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sequencer.sv
// i2c_sequencer: turns one register-style request (address, direction,
// 1..4 bytes) into a START/address, data-byte and STOP command sequence
// for a byte-level I2C master. Any ISSUE_*/WAIT_* state that lasts too
// long aborts straight to DONE with an error flag and no STOP.
module i2c_sequencer #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int TO_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    // request / response side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_addr,
    input  logic        req_rw,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    // byte-level master side
    output logic        i2c_en,
    output logic        start,
    output logic        stop,
    output logic [7:0]  tx_data,
    input  logic        ready,
    input  logic [7:0]  rx_data,
    input  logic        tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_ADDR,
        WAIT_ADDR,
        ISSUE_DATA,
        WAIT_DATA,
        ISSUE_STOP,
        WAIT_STOP,
        DONE
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              seen_low_q, seen_low_d;
    logic              err_q, err_d;
    logic [6:0]        addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [1:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              en_c, start_c, stop_c;
    logic [7:0]        tx_c;
    logic              in_timed;
    logic              timeout;
    logic              cmd_done;
    logic [7:0]        wbyte [4];

    // tx_done is informational only; sequencing relies on ready alone
    logic              unused_tx_done;
    assign unused_tx_done = tx_done;

    // split the latched write word into bytes, byte 0 goes out first
    for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
        assign wbyte[gi] = wdata_q[8*gi +: 8];
    end

    // state register and all datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            to_cnt_q   <= '0;
            seen_low_q <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            len_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            to_cnt_q   <= to_cnt_d;
            seen_low_q <= seen_low_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // next-state, command outputs, timeout and completion tracking
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        seen_low_d = seen_low_q;
        to_cnt_d   = to_cnt_q;
        en_c       = 1'b0;
        start_c    = 1'b0;
        stop_c     = 1'b0;
        tx_c       = 8'h00;

        in_timed = (state_q != IDLE) && (state_q != DONE);
        timeout  = in_timed && (to_cnt_q == TO_LIMIT);
        // a command finishes only once ready has been seen low after acceptance
        cmd_done = seen_low_q && ready;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    rw_d    = req_rw;
                    len_d   = req_len;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE_ADDR;
                end
            end
            ISSUE_ADDR: begin
                en_c    = 1'b1;
                start_c = 1'b1;
                tx_c    = {addr_q, rw_q};
                if (ready) state_d = WAIT_ADDR;
            end
            WAIT_ADDR: begin
                if (cmd_done) begin
                    idx_d   = '0;
                    state_d = ISSUE_DATA;
                end
            end
            ISSUE_DATA: begin
                en_c = 1'b1;
                tx_c = rw_q ? 8'h00 : wbyte[idx_q];
                if (ready) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (cmd_done) begin
                    if (rw_q) rdata_d[{idx_q, 3'b000} +: 8] = rx_data;
                    if (idx_q == len_q) begin
                        state_d = ISSUE_STOP;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE_DATA;
                    end
                end
            end
            ISSUE_STOP: begin
                en_c   = 1'b1;
                stop_c = 1'b1;
                if (ready) state_d = WAIT_STOP;
            end
            WAIT_STOP: begin
                if (cmd_done) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // timeout wins over everything: abandon the command, no STOP
        if (timeout) begin
            state_d = DONE;
            err_d   = 1'b1;
            idx_d   = idx_q;
            rdata_d = rdata_q;
            en_c    = 1'b0;
            start_c = 1'b0;
            stop_c  = 1'b0;
            tx_c    = 8'h00;
        end

        if (state_d != state_q) begin
            seen_low_d = 1'b0;
            to_cnt_d   = '0;
        end else begin
            if ((state_q == WAIT_ADDR || state_q == WAIT_DATA ||
                 state_q == WAIT_STOP) && !ready) begin
                seen_low_d = 1'b1;
            end
            to_cnt_d = in_timed ? (to_cnt_q + TO_ONE) : '0;
        end
    end

    // outputs are forced quiet while reset is held
    always_comb begin
        req_ready = !reset && (state_q == IDLE);
        busy      = !reset && (state_q != IDLE);
        rsp_valid = !reset && (state_q == DONE);
        rsp_err   = !reset && (state_q == DONE) && err_q;
        rsp_rdata = reset ? 32'h0 : rdata_q;
        i2c_en    = !reset && en_c;
        start     = !reset && start_c;
        stop      = !reset && stop_c;
        tx_data   = reset ? 8'h00 : tx_c;
    end

endmodule

// File: tb/tb_i2c_sequencer.sv
// Directed bench for i2c_sequencer with a small behavioural byte master.
module tb_i2c_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_addr = '0;
    logic        req_rw = 1'b0;
    logic [1:0]  req_len = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy, i2c_en, start, stop;
    logic [7:0]  tx_data;
    logic        m_ready = 1'b1;
    logic [7:0]  m_rx = 8'h00;
    logic        m_tx_done = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;

    // master model state
    int          m_busy = 0;
    int          m_mode = 0;   // 0 normal, 1 stall low after accept, 2 never drop ready
    logic [9:0]  cmd_log [$];
    logic [9:0]  exp_log [$];
    logic [7:0]  rx_q    [$];

    i2c_sequencer #(.TIMEOUT_CYC(20), .TO_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .i2c_en    (i2c_en),
        .start     (start),
        .stop      (stop),
        .tx_data   (tx_data),
        .ready     (m_ready),
        .rx_data   (m_rx),
        .tx_done   (m_tx_done)
    );

    always #5 clk = ~clk;

    // byte master: logs accepted commands, goes busy for three cycles
    always @(posedge clk) begin
        m_tx_done <= 1'b0;
        if (reset) begin
            m_ready <= 1'b1;
            m_busy  <= 0;
        end else if (!m_ready) begin
            if (m_mode != 1) begin
                if (m_busy == 0) begin
                    m_ready   <= 1'b1;
                    m_tx_done <= 1'b1;
                end else begin
                    m_busy <= m_busy - 1;
                end
            end
        end else if (i2c_en) begin
            cmd_log.push_back({start, stop, tx_data});
            if (m_mode != 2) begin
                m_ready <= 1'b0;
                m_busy  <= 2;
            end
            if (!start && !stop && rx_q.size() != 0) m_rx <= rx_q.pop_front();
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, ".ncmd"}, 64'(cmd_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++)
            chk($sformatf("%s.cmd%0d", tag, i), 64'(cmd_log[i]), 64'(exp_log[i]));
    endtask

    // present a request, check the accept-to-command latency, wait for rsp_valid
    task automatic do_txn(input string tag, input logic [6:0] a, input logic rw,
                          input logic [1:0] len, input logic [31:0] wd,
                          input logic [7:0] exp_abyte, output int cyc);
        @(negedge clk);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(1));
        cmd_log.delete();
        req_valid = 1'b1;
        req_addr  = a;
        req_rw    = rw;
        req_len   = len;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".addr_cmd"}, 64'({i2c_en, start, stop, tx_data}),
            64'({1'b1, 1'b1, 1'b0, exp_abyte}));
        chk({tag, ".busy"}, 64'({busy, req_ready}), 64'(2'b10));
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".rsp_seen"}, 64'(rsp_valid), 64'(1));
    endtask

    // response fields at DONE, then the single-cycle pulse and held data
    task automatic post_txn(input string tag, input logic exp_err, input logic [31:0] exp_rd);
        chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
        chk({tag, ".rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        chk({tag, ".en_at_done"}, 64'(i2c_en), 64'(0));
        @(negedge clk);
        chk({tag, ".pulse"}, 64'({rsp_valid, req_ready, busy}), 64'(3'b010));
        chk({tag, ".rdata_hold"}, 64'(rsp_rdata), 64'(exp_rd));
        chk_log(tag);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        int cnt;
        int pulses;
        int rr;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.outs", 64'({req_ready, busy, rsp_valid, rsp_err, i2c_en, start, stop}), 64'(0));
        chk("rst.data", 64'({rsp_rdata, tx_data}), 64'(0));
        reset = 1'b0;
        #1;
        chk("rst.req_ready_after", 64'(req_ready), 64'(1));

        // write 0x50, 2 bytes 0xEF,0xBE
        do_txn("wr2", 7'h50, 1'b0, 2'd1, 32'h0000_BEEF, 8'hA0, cyc);
        exp_log = '{10'h2A0, 10'h0EF, 10'h0BE, 10'h100};
        post_txn("wr2", 1'b0, 32'h0);

        // read 0x55, 4 bytes
        rx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_txn("rd4", 7'h55, 1'b1, 2'd3, 32'hFFFF_FFFF, 8'hAB, cyc);
        exp_log = '{10'h2AB, 10'h000, 10'h000, 10'h000, 10'h000, 10'h100};
        post_txn("rd4", 1'b0, 32'h4433_2211);

        // read 0x2D, 1 byte: upper bytes cleared on accept
        rx_q = '{8'h5A};
        do_txn("rd1", 7'h2D, 1'b1, 2'd0, 32'h0, 8'h5B, cyc);
        exp_log = '{10'h25B, 10'h000, 10'h100};
        post_txn("rd1", 1'b0, 32'h0000_005A);

        // reset clears held read data
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2.rdata", 64'(rsp_rdata), 64'(0));
        reset = 1'b0;
        #1;
        chk("rst2.after", 64'({req_ready, rsp_rdata}), 64'({1'b1, 32'h0}));

        // master stalls with ready low after the address command
        m_mode = 1;
        do_txn("to_low", 7'h3C, 1'b0, 2'd2, 32'h0012_3456, 8'h78, cyc);
        chk("to_low.cycles", 64'(cyc), 64'(21));
        exp_log = '{10'h278};
        post_txn("to_low", 1'b1, 32'h0);
        pulse_reset();
        m_mode = 0;

        // ready never drops after acceptance: resolves only by timeout
        m_mode = 2;
        do_txn("to_high", 7'h11, 1'b1, 2'd0, 32'h0, 8'h23, cyc);
        chk("to_high.cycles", 64'(cyc), 64'(21));
        exp_log = '{10'h223};
        post_txn("to_high", 1'b1, 32'h0);
        pulse_reset();
        m_mode = 0;

        // reset during WAIT_DATA aborts silently
        @(negedge clk);
        cmd_log.delete();
        req_valid = 1'b1;
        req_addr  = 7'h40;
        req_rw    = 1'b0;
        req_len   = 2'd0;
        req_wdata = 32'h0000_0099;
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        while (cmd_log.size() < 2 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("rstmid.reached_wait", 64'(cmd_log.size()), 64'(2));
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid.quiet", 64'({i2c_en, busy, rsp_valid}), 64'(0));
        reset = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("rstmid.no_rsp", 64'(pulses), 64'(0));
        chk("rstmid.idle", 64'({req_ready, busy}), 64'(2'b10));

        // a normal write after the aborted one
        do_txn("wr_after", 7'h50, 1'b0, 2'd1, 32'h0000_1234, 8'hA0, cyc);
        exp_log = '{10'h2A0, 10'h034, 10'h012, 10'h100};
        post_txn("wr_after", 1'b0, 32'h0);

        // back-to-back requests with req_valid held high
        @(negedge clk);
        cmd_log.delete();
        req_valid = 1'b1;
        req_addr  = 7'h0A;
        req_rw    = 1'b0;
        req_len   = 2'd0;
        req_wdata = 32'h0000_00C3;
        @(negedge clk);
        chk("b2b.first_cmd", 64'({i2c_en, start, tx_data}), 64'({1'b1, 1'b1, 8'h14}));
        cyc = 0;
        rr = 0;
        while (!rsp_valid && cyc < 300) begin
            @(negedge clk);
            if (req_ready) rr++;
            cyc++;
        end
        chk("b2b.first_rsp", 64'({rsp_valid, rsp_err}), 64'(2'b10));
        chk("b2b.no_ready_busy", 64'(rr), 64'(0));
        req_addr  = 7'h12;
        req_wdata = 32'h0000_0077;
        @(negedge clk);
        chk("b2b.idle_gap", 64'({req_ready, busy, rsp_valid}), 64'(3'b100));
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b.second_cmd", 64'({i2c_en, start, tx_data, req_ready}),
            64'({1'b1, 1'b1, 8'h24, 1'b0}));
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b.second_rsp", 64'(rsp_valid), 64'(1));
        exp_log = '{10'h214, 10'h0C3, 10'h100, 10'h224, 10'h077, 10'h100};
        post_txn("b2b", 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
